abacus_wb_scan_master: RTL and testbench
========================================

# abacus_wb_scan_master

Wishbone classic read initiator that sweeps a contiguous window of ABACUS profiler counter registers and streams each word out on a valid/ready interface. It sits on the system bus beside the CPU as a second bus master. Each scan is either triggered on demand or started by an internal periodic timer, so counter snapshots reach a logger or debug link without software polling.

## Interface
Parameters:
- SCAN_BASE_ADDR, 32'hf0030100, byte address of the first word read; must be 4-byte aligned.
- NUM_WORDS, 11, number of consecutive 32-bit words per scan; legal range 1..256.
- PERIOD_CYCLES, 0, auto-trigger interval in clk cycles; 0 disables auto-trigger.
- ACK_TIMEOUT, 16, maximum cycles to wait for wb_ack per read; must be ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: asynchronous, active-high.
- start  in  1  one-cycle scan request.
- busy  out  1  high from the scan-start cycle until done.
- done  out  1  one-cycle pulse when a scan ends, whether completed or aborted.
- error  out  1  sticky timeout flag; cleared when the next scan starts.
- wb_cyc  out  1  bus cycle.
- wb_stb  out  1  strobe.
- wb_we  out  1  tied 0; the block only reads.
- wb_adr  out  32  read address.
- wb_dat_o  out  32  tied 0.
- wb_dat_i  in  32  read data.
- wb_ack  in  1  responder acknowledge.
- m_valid  out  1  stream word valid.
- m_ready  in  1  downstream accept.
- m_data  out  32  captured counter value.
- m_index  out  8  word index 0..NUM_WORDS-1.
- m_last  out  1  high with the final word of a scan.

## Operation
- FSM states: IDLE, READ, PUSH.
- IDLE:
  - A scan trigger is start=1, or the period timer reaching PERIOD_CYCLES-1.
  - On a trigger: set index to 0 and clear error. The same edge enters READ with wb_cyc=wb_stb=1 and wb_adr=SCAN_BASE_ADDR.
- READ:
  - wb_cyc and wb_stb are held high until wb_ack is sampled.
  - wb_adr = SCAN_BASE_ADDR + 4*index, computed with 32-bit wrap.
  - On the edge where wb_ack=1:
    - m_data <= wb_dat_i, m_index <= index, m_last <= (index==NUM_WORDS-1).
    - wb_cyc and wb_stb drop to 0 and m_valid goes to 1.
    - The FSM enters PUSH.
  - Timeout counter: reset on entry to READ and incremented each cycle without ack. When it reaches ACK_TIMEOUT-1 with no ack:
    - drop wb_cyc and wb_stb;
    - set error, pulse done, return to IDLE;
    - emit no stream word.
- PUSH:
  - m_valid is held with m_data, m_index and m_last stable until m_ready=1.
  - On handshake, if m_last: m_valid goes to 0, done pulses, the FSM returns to IDLE.
  - On handshake, otherwise: index increments, m_valid goes to 0, the FSM enters READ.
- Period timer:
  - Counts only in IDLE when PERIOD_CYCLES≠0.
  - Held at 0 while busy.
  - Resets to 0 when any scan starts.
- start while busy is ignored; no queuing.
- A start on the same cycle the period timer fires produces exactly one scan.
- busy = (state≠IDLE).
- error stays high after an aborted scan until the next scan starts.

## Timing
- Reset values: every output is 0; state=IDLE; index, period timer and timeout counter are 0.
- rst asserted mid-scan forces wb_cyc, wb_stb and m_valid low immediately, without waiting for a clock edge.
- The FSM never asserts wb_stb in the cycle after an ack. This satisfies responders that toggle ack while stb stays high.
- Per-word latency with a one-cycle-ack responder and m_ready held high is 3 cycles:
  - cycle 0: READ, stb=1;
  - cycle 1: ack=1;
  - cycle 2: PUSH, m_valid=1, handshake;
  - cycle 3: next READ.
- A full scan therefore takes 3*NUM_WORDS cycles from the trigger edge to the done pulse. done is asserted in the cycle after the last handshake.
- m_ready held low stalls the FSM indefinitely in PUSH. No bus activity occurs while stalled.
- Only one word is in flight at a time; the output buffer holds one entry.

## Test plan
- **Single-ack scan:** responder acks one cycle after stb and returns 0x100+4*i; m_ready=1; pulse start.
  - 11 words with m_data=0x100..0x128 and m_index 0..10.
  - m_last only on index 10.
  - done 33 cycles after the start edge; error=0.
- **Backpressure:** hold m_ready=0 for 5 cycles on word 3.
  - m_data, m_index and m_last are stable throughout.
  - wb_cyc stays 0 during the stall.
  - The scan completes with no loss or duplication.
- **Timeout:** responder never acks word 2.
  - wb_stb drops after 16 cycles in READ; error=1 and done pulses.
  - Only indices 0 and 1 are emitted.
  - The next start clears error.
- **Auto-trigger:** PERIOD_CYCLES=100, no start.
  - A scan begins after 100 idle cycles and recurs 100 cycles after each done.
  - A start pulsed during a scan is ignored.
- **Reset mid-scan:** assert rst while in READ.
  - wb_cyc, wb_stb, m_valid, busy and error go to 0 immediately.
  - After release, a new start produces a clean scan from index 0.

Source files
------------

// File: rtl/abacus_wb_scan_master.sv
// Wishbone classic read master that sweeps NUM_WORDS counter registers and streams each word out,
// one word in flight; 3 cycles per word with a one-cycle-ack responder; m_ready low stalls the FSM in PUSH.
module abacus_wb_scan_master #(
    parameter logic [31:0] SCAN_BASE_ADDR = 32'hf0030100,
    parameter int unsigned NUM_WORDS      = 11,
    parameter int unsigned PERIOD_CYCLES  = 0,
    parameter int unsigned ACK_TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [31:0] wb_adr,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic [7:0]  m_index,
    output logic        m_last
);

    typedef enum logic [1:0] {IDLE, READ, PUSH} state_t;

    localparam logic [7:0]  LAST_IDX = 8'(NUM_WORDS - 1);
    localparam logic [31:0] TMO_LAST = 32'(ACK_TIMEOUT - 1);
    localparam logic [31:0] PER_LAST = 32'(PERIOD_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [31:0] tmo_q, tmo_d;
    logic [31:0] per_q, per_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [31:0] data_q, data_d;
    logic [7:0]  m_index_q, m_index_d;
    logic        last_q, last_d;
    logic        timer_fire;

    assign timer_fire = (PERIOD_CYCLES != 0) && (per_q == PER_LAST);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tmo_d     = tmo_q;
        per_d     = '0;
        done_d    = 1'b0;
        error_d   = error_q;
        data_d    = data_q;
        m_index_d = m_index_q;
        last_d    = last_q;
        case (state_q)
            IDLE: begin
                // start and a timer expiry in the same cycle merge into one scan
                if (start || timer_fire) begin
                    state_d = READ;
                    idx_d   = '0;
                    tmo_d   = '0;
                    error_d = 1'b0;
                end else if (PERIOD_CYCLES != 0) begin
                    per_d = per_q + 32'd1;
                end
            end
            READ: begin
                if (wb_ack) begin
                    data_d    = wb_dat_i;
                    m_index_d = idx_q;
                    last_d    = (idx_q == LAST_IDX);
                    state_d   = PUSH;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = IDLE;
                    error_d = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            PUSH: begin
                if (m_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        tmo_d   = '0;
                        state_d = READ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            tmo_q     <= '0;
            per_q     <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            data_q    <= '0;
            m_index_q <= '0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            tmo_q     <= tmo_d;
            per_q     <= per_d;
            done_q    <= done_d;
            error_q   <= error_d;
            data_q    <= data_d;
            m_index_q <= m_index_d;
            last_q    <= last_d;
        end
    end

    // Bus and stream strobes decode straight from the state so reset removes them asynchronously
    assign wb_cyc   = (state_q == READ);
    assign wb_stb   = (state_q == READ);
    assign wb_we    = 1'b0;
    assign wb_dat_o = '0;
    assign wb_adr   = (state_q == READ) ? (SCAN_BASE_ADDR + {22'd0, idx_q, 2'b00}) : '0;
    assign m_valid  = (state_q == PUSH);
    assign m_data   = data_q;
    assign m_index  = m_index_q;
    assign m_last   = last_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign error    = error_q;

endmodule

// File: tb/tb_abacus_wb_scan_master.sv
// Directed bench for abacus_wb_scan_master: table of scan scenarios plus reset and auto-trigger sequences.
module tb_abacus_wb_scan_master;

    localparam logic [31:0] BASE = 32'hf0030100;
    localparam int NW = 11;

    logic        clk, rst, start, busy, done, error, wb_cyc, wb_stb, wb_we, wb_ack;
    logic [31:0] wb_adr, wb_dat_o, wb_dat_i, m_data;
    logic        m_valid, m_ready, m_last;
    logic [7:0]  m_index;

    logic        a_rst, a_start, a_busy, a_done, a_error, a_cyc, a_stb, a_we, a_ack;
    logic [31:0] a_adr, a_dat_o, a_dat_i, a_data;
    logic        a_valid, a_ready, a_last;
    logic [7:0]  a_index;

    int noack_word;

    abacus_wb_scan_master #(.SCAN_BASE_ADDR(BASE), .NUM_WORDS(NW), .PERIOD_CYCLES(0), .ACK_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr), .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i), .wb_ack(wb_ack), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_index(m_index), .m_last(m_last)
    );

    abacus_wb_scan_master #(.SCAN_BASE_ADDR(BASE), .NUM_WORDS(NW), .PERIOD_CYCLES(100), .ACK_TIMEOUT(16)) dut_auto (
        .clk(clk), .rst(a_rst), .start(a_start), .busy(a_busy), .done(a_done), .error(a_error),
        .wb_cyc(a_cyc), .wb_stb(a_stb), .wb_we(a_we), .wb_adr(a_adr), .wb_dat_o(a_dat_o),
        .wb_dat_i(a_dat_i), .wb_ack(a_ack), .m_valid(a_valid), .m_ready(a_ready),
        .m_data(a_data), .m_index(a_index), .m_last(a_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Responders: ack one cycle after stb, data = 0x100 + byte offset
    assign wb_dat_i = 32'h100 + (wb_adr - BASE);
    assign a_dat_i  = 32'h100 + (a_adr - BASE);

    always @(posedge clk or posedge rst) begin
        if (rst) wb_ack <= 1'b0;
        else     wb_ack <= wb_cyc && wb_stb && !wb_ack &&
                           !(noack_word >= 0 && wb_adr == BASE + 32'(noack_word * 4));
    end

    always @(posedge clk or posedge a_rst) begin
        if (a_rst) a_ack <= 1'b0;
        else       a_ack <= a_cyc && a_stb && !a_ack;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int noack;
        int stall_w;
        int stall_n;
        int restart_at;
        int exp_n;
        bit exp_err;
        int exp_done;
        int exp_stb_last;
    } vec_t;

    logic [40:0] words[$];
    int  done_at, done_cnt, stb_last;
    logic err0, err_done;

    task automatic run_scan(input int noack, input int stall_w, input int stall_n, input int restart_at);
        logic [40:0] cur, held;
        bit was_stalled;
        int stall_cnt;
        noack_word = noack;
        words.delete();
        done_at = -1; done_cnt = 0; stb_last = -1; stall_cnt = 0; was_stalled = 0;
        err0 = 1'bx; err_done = 1'bx; held = '0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            if (m_valid && int'(m_index) == stall_w && stall_cnt < stall_n) begin
                m_ready = 1'b0;
                stall_cnt++;
            end else begin
                m_ready = 1'b1;
            end
            start = (c == restart_at);
            cur = {m_data, m_index, m_last};
            if (m_valid && was_stalled) chk("stall_hold", cur, held);
            if (m_valid && !m_ready) begin
                held = cur;
                was_stalled = 1;
                chk("stall_cyc", wb_cyc, 1'b0);
            end else begin
                was_stalled = 0;
            end
            if (wb_stb) stb_last = c;
            if (c == 0) err0 = error;
            if (done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = c;
                    err_done = error;
                end
            end
            if (m_valid && m_ready) words.push_back(cur);
        end
        m_ready = 1'b1;
    endtask

    task automatic check_scan(input vec_t v);
        logic [40:0] e;
        chk("word_count", words.size(), v.exp_n);
        foreach (words[i]) begin
            e = {32'(32'h100 + 4 * i), 8'(i), (i == NW - 1)};
            chk("word", words[i], e);
        end
        chk("done_count", done_cnt, 1);
        chk("done_cycle", done_at, v.exp_done);
        chk("err_at_start", err0, 1'b0);
        chk("err_at_done", err_done, v.exp_err);
        chk("stb_last_cycle", stb_last, v.exp_stb_last);
        chk("busy_after", busy, 1'b0);
    endtask

    vec_t vecs[6];
    vec_t clean;
    int rises[$], dones[$];
    bit prev_busy;

    initial begin
        vecs[0] = '{-1, -1, 0, -1, 11, 1'b0, 33, 31};  // single-ack scan
        vecs[1] = '{-1,  3, 5, -1, 11, 1'b0, 38, 36};  // 5-cycle stall on word 3
        vecs[2] = '{ 2, -1, 0, -1,  2, 1'b1, 22, 21};  // word 2 never acked
        vecs[3] = '{-1, -1, 0, -1, 11, 1'b0, 33, 31};  // next start clears error
        vecs[4] = '{ 0, -1, 0, -1,  0, 1'b1, 16, 15};  // timeout on the first word
        vecs[5] = '{-1, -1, 0, 10, 11, 1'b0, 33, 31};  // start while busy ignored
        clean = vecs[0];

        rst = 1'b1; a_rst = 1'b1; start = 1'b0; a_start = 1'b0;
        m_ready = 1'b1; a_ready = 1'b1; noack_word = -1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", {busy, done, error, wb_cyc, wb_stb, wb_we, m_valid, m_last}, 8'h00);
        chk("reset_bus", {wb_adr, wb_dat_o}, 64'h0);
        chk("reset_stream", {m_data, m_index}, 40'h0);
        @(negedge clk) rst = 1'b0;
        repeat (20) @(posedge clk);
        #1 chk("idle_no_auto", busy, 1'b0);

        for (int k = 0; k < 6; k++) begin
            run_scan(vecs[k].noack, vecs[k].stall_w, vecs[k].stall_n, vecs[k].restart_at);
            check_scan(vecs[k]);
        end

        // Reset while READ of word 1 is in progress
        noack_word = -1;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 chk("pre_rst_stb", wb_stb, 1'b1);
        rst = 1'b1;
        #1 chk("rst_async", {wb_cyc, wb_stb, m_valid, busy, error}, 5'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        run_scan(clean.noack, clean.stall_w, clean.stall_n, clean.restart_at);
        check_scan(clean);

        // Auto-trigger instance: start during a scan is ignored, start coinciding with the timer gives one scan
        prev_busy = 1'b0;
        @(posedge clk); #1 a_rst = 1'b0;
        for (int j = 0; j < 400; j++) begin
            @(negedge clk);
            if (a_busy && !prev_busy) rises.push_back(j);
            prev_busy = a_busy;
            if (a_done) dones.push_back(j);
            a_start = (j == 110 || j == 232);
        end
        a_start = 1'b0;
        chk("auto_rise_count", rises.size(), 3);
        chk("auto_done_count", dones.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < rises.size()) chk("auto_rise_cycle", rises[i], 100 + 133 * i);
            if (i < dones.size()) chk("auto_done_cycle", dones[i], 133 + 133 * i);
        end
        chk("auto_error", a_error, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
